// File: rtl/board_state_if.sv
// Link between this board and the opponent's board.
// master: board_state (accepts remote moves, offers local moves).
// slave:  the inter-board link.
interface board_state_if;
  logic        remote_valid;
  logic [11:0] remote_packet;
  logic        remote_ready;
  logic        tx_valid;
  logic [11:0] tx_packet;
  logic        tx_ready;

  modport master (
    input  remote_valid,
    input  remote_packet,
    output remote_ready,
    output tx_valid,
    output tx_packet,
    input  tx_ready
  );

  modport slave (
    output remote_valid,
    output remote_packet,
    input  remote_ready,
    input  tx_valid,
    input  tx_packet,
    output tx_ready
  );
endinterface

// File: rtl/board_state.sv
// board_state: authoritative 8x8 board register file and turn arbiter.
// Commits local moves (then forwards them on the link) and remote moves;
// every move is applied exactly once and the turn toggles only after a commit.

typedef enum logic [1:0] {
  SPLASH_SCREEN = 2'd0,
  CHESS_SCREEN  = 2'd1,
  END_SCREEN    = 2'd2
} screen_state_t;

module board_state (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  screen_state_t          sys_state,
  input  logic                   player,
  input  logic                   local_moved,
  input  logic [11:0]            local_packet,
  board_state_if.master          link,
  output logic [7:0][7:0][3:0]   stable_board,
  output logic                   curr_player,
  output logic [7:0]             move_count,
  output logic                   move_err
);

  localparam logic [3:0] Empty = 4'd15;

  typedef enum logic [1:0] {StIdle, StApplyL, StApplyR, StSend} state_e;

  state_e      state_q;
  logic        moved_q;
  logic [11:0] pkt_q;

  logic        active;
  logic        local_req;
  logic        take_local;
  logic [2:0]  src_row, src_col, dst_row, dst_col;
  logic [3:0]  src_piece;
  logic        pkt_ok;

  // Starting layout: black back rank on row 0, white back rank on row 7.
  function automatic logic [7:0][7:0][3:0] init_board();
    logic [7:0][7:0][3:0] b;
    logic [3:0]           back;
    for (int unsigned c = 0; c < 8; c++) begin
      case (c[2:0])
        3'd0, 3'd7: back = 4'd0;
        3'd1, 3'd6: back = 4'd1;
        3'd2, 3'd5: back = 4'd2;
        3'd3:       back = 4'd3;
        default:    back = 4'd4;
      endcase
      for (int unsigned r = 0; r < 8; r++) begin
        b[r[2:0]][c[2:0]] = Empty;
      end
      b[0][c[2:0]] = back + 4'd6;
      b[1][c[2:0]] = 4'd11;
      b[6][c[2:0]] = 4'd5;
      b[7][c[2:0]] = back;
    end
    return b;
  endfunction

  assign active     = (sys_state == CHESS_SCREEN);
  // Only the rising edge of the 8-cycle level counts as a request.
  assign local_req  = local_moved && !moved_q;
  assign take_local = (state_q == StIdle) && active && local_req && (curr_player == player);

  assign link.remote_ready = (state_q == StIdle) && link.remote_valid &&
                             (curr_player != player) && !local_req && active;

  assign src_row   = pkt_q[11:9];
  assign src_col   = pkt_q[8:6];
  assign dst_row   = pkt_q[5:3];
  assign dst_col   = pkt_q[2:0];
  assign src_piece = stable_board[src_row][src_col];
  assign pkt_ok    = (pkt_q[11:6] != pkt_q[5:0]) && (src_piece != Empty);

  // Turn FSM with registered board, counters and link outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= StIdle;
      moved_q        <= 1'b0;
      pkt_q          <= 12'h000;
      stable_board   <= init_board();
      curr_player    <= 1'b1;
      move_count     <= 8'd0;
      move_err       <= 1'b0;
      link.tx_valid  <= 1'b0;
      link.tx_packet <= 12'h000;
    end else begin
      moved_q  <= local_moved;
      move_err <= 1'b0;
      case (state_q)
        StIdle: begin
          if (take_local) begin
            pkt_q   <= local_packet;
            state_q <= StApplyL;
          end else if (link.remote_ready) begin
            pkt_q   <= link.remote_packet;
            state_q <= StApplyR;
          end
        end
        StApplyL, StApplyR: begin
          if (pkt_ok) begin
            // A capture is just an overwrite of the destination square.
            stable_board[dst_row][dst_col] <= src_piece;
            stable_board[src_row][src_col] <= Empty;
            move_count <= move_count + 8'd1;
            if (state_q == StApplyL) begin
              link.tx_valid  <= 1'b1;
              link.tx_packet <= pkt_q;
              state_q        <= StSend;
            end else begin
              curr_player <= ~curr_player;
              state_q     <= StIdle;
            end
          end else begin
            move_err <= 1'b1;
            state_q  <= StIdle;
          end
        end
        StSend: begin
          // Turn passes only once the opponent's link has taken the move.
          if (link.tx_ready) begin
            link.tx_valid <= 1'b0;
            curr_player   <= ~curr_player;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_board_state.sv
// Directed bench for board_state: stimulus pushes expected link/error events
// into a queue; a negedge monitor pops and compares them as they appear.
module tb_board_state;

  logic                 CLOCK_50;
  logic                 reset;
  screen_state_t        sys_state;
  logic                 player;
  logic                 local_moved;
  logic [11:0]          local_packet;
  logic [7:0][7:0][3:0] stable_board;
  logic                 curr_player;
  logic [7:0]           move_count;
  logic                 move_err;

  board_state_if link ();

  board_state dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .sys_state    (sys_state),
    .player       (player),
    .local_moved  (local_moved),
    .local_packet (local_packet),
    .link         (link),
    .stable_board (stable_board),
    .curr_player  (curr_player),
    .move_count   (move_count),
    .move_err     (move_err)
  );

  typedef enum {EvTx, EvErr, EvRacc} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [11:0] pkt;
  } ev_t;

  ev_t                  exp_q[$];
  int                   n_cmp = 0;
  int                   n_bad = 0;
  int                   bad;
  logic [7:0][7:0][3:0] exp_board;
  int                   top_row  [8] = '{6, 7, 8, 9, 10, 8, 7, 6};
  int                   back_row [8] = '{0, 1, 2, 3, 4, 2, 1, 0};

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    chk(name, 256'(act), 256'(req));
  endtask

  task automatic chk12(input string name, input logic [11:0] act, input logic [11:0] req);
    chk(name, 256'(act), 256'(req));
  endtask

  task automatic chki(input string name, input int act, input int req);
    chk(name, 256'(act), 256'(req));
  endtask

  task automatic chkb(input string name);
    chk(name, stable_board, exp_board);
  endtask

  task automatic check_ev(input ev_kind_e kind, input logic [11:0] pkt);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got %s %h required none", kind.name(), pkt);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.pkt !== pkt) begin
        n_bad++;
        $display("FAIL event: got %s %h required %s %h", kind.name(), pkt, e.kind.name(), e.pkt);
      end
    end
  endtask

  // Monitor: every observable link handshake or error pulse must be expected.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (link.tx_valid && link.tx_ready) check_ev(EvTx, link.tx_packet);
      if (move_err) check_ev(EvErr, 12'h000);
      if (link.remote_valid && link.remote_ready) check_ev(EvRacc, link.remote_packet);
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic exp_reset();
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) exp_board[r[2:0]][c[2:0]] = 4'd15;
      exp_board[0][c[2:0]] = 4'(top_row[c]);
      exp_board[1][c[2:0]] = 4'd11;
      exp_board[6][c[2:0]] = 4'd5;
      exp_board[7][c[2:0]] = 4'(back_row[c]);
    end
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    local_moved       = 1'b0;
    link.remote_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_reset();
  endtask

  initial begin
    reset              = 1'b1;
    sys_state          = CHESS_SCREEN;
    player             = 1'b1;
    local_moved        = 1'b0;
    local_packet       = 12'h000;
    link.remote_valid  = 1'b0;
    link.remote_packet = 12'h000;
    link.tx_ready      = 1'b0;

    // Reset state.
    do_reset();
    chkb("reset_board");
    chk1("reset_curr_player", curr_player, 1'b1);
    chki("reset_move_count", int'(move_count), 0);
    chk1("reset_tx_valid", link.tx_valid, 1'b0);
    chk12("reset_tx_packet", link.tx_packet, 12'h000);
    chk1("reset_move_err", move_err, 1'b0);

    // Local move {6,4,4,4}: 8-cycle level, tx_ready late.
    player       = 1'b1;
    local_packet = 12'hD24;
    local_moved  = 1'b1;
    exp_q.push_back('{EvTx, 12'hD24});
    tick();
    chk1("local_apply_no_tx", link.tx_valid, 1'b0);
    chkb("local_apply_board_held");
    tick();
    exp_board[4][4] = 4'd5;
    exp_board[6][4] = 4'd15;
    chkb("local_commit_board");
    chki("local_commit_count", int'(move_count), 1);
    chk1("local_tx_valid", link.tx_valid, 1'b1);
    chk12("local_tx_packet", link.tx_packet, 12'hD24);
    chk1("local_turn_held", curr_player, 1'b1);
    tick();
    link.tx_ready = 1'b1;
    tick();
    link.tx_ready = 1'b0;
    chk1("local_turn_toggled", curr_player, 1'b0);
    chk1("local_tx_dropped", link.tx_valid, 1'b0);
    repeat (4) tick();
    local_moved = 1'b0;
    repeat (3) tick();
    chki("local_no_second_commit", int'(move_count), 1);
    chkb("local_board_after_level");

    // Remote move {6,3,5,3} accepted by player 0.
    do_reset();
    player             = 1'b0;
    link.remote_packet = 12'hCEB;
    link.remote_valid  = 1'b1;
    exp_q.push_back('{EvRacc, 12'hCEB});
    #1;
    chk1("remote_ready_pulse", link.remote_ready, 1'b1);
    tick();
    link.remote_valid = 1'b0;
    chk1("remote_apply_turn_held", curr_player, 1'b1);
    tick();
    exp_board[5][3] = 4'd5;
    exp_board[6][3] = 4'd15;
    chkb("remote_commit_board");
    chk1("remote_turn_toggled", curr_player, 1'b0);
    chki("remote_commit_count", int'(move_count), 1);

    // Remote move from empty square {3,3,4,4} is rejected.
    player             = 1'b1;
    link.remote_packet = 12'h6E4;
    link.remote_valid  = 1'b1;
    exp_q.push_back('{EvRacc, 12'h6E4});
    exp_q.push_back('{EvErr, 12'h000});
    tick();
    link.remote_valid = 1'b0;
    tick();
    chk1("reject_err_high", move_err, 1'b1);
    tick();
    chk1("reject_err_one_cycle", move_err, 1'b0);
    chkb("reject_board_held");
    chki("reject_count_held", int'(move_count), 1);
    chk1("reject_turn_held", curr_player, 1'b0);

    // Local edge and remote_valid together while in turn: local wins.
    player             = 1'b0;
    local_packet       = 12'h218;
    local_moved        = 1'b1;
    link.remote_packet = 12'hC20;
    link.remote_valid  = 1'b1;
    link.tx_ready      = 1'b1;
    exp_q.push_back('{EvTx, 12'h218});
    #1;
    chk1("collide_remote_ready_low", link.remote_ready, 1'b0);
    tick();
    chk1("collide_ready_low_apply", link.remote_ready, 1'b0);
    tick();
    exp_board[3][0] = 4'd11;
    exp_board[1][0] = 4'd15;
    chkb("collide_local_board");
    chki("collide_local_count", int'(move_count), 2);
    exp_q.push_back('{EvRacc, 12'hC20});
    tick();
    local_moved   = 1'b0;
    link.tx_ready = 1'b0;
    chk1("collide_turn_passed", curr_player, 1'b1);
    chk1("collide_tx_dropped", link.tx_valid, 1'b0);
    #1;
    chk1("collide_remote_ready_now", link.remote_ready, 1'b1);
    tick();
    link.remote_valid = 1'b0;
    tick();
    exp_board[4][0] = 4'd5;
    exp_board[6][0] = 4'd15;
    chkb("collide_remote_board");
    chk1("collide_remote_turn", curr_player, 1'b0);
    chki("collide_remote_count", int'(move_count), 3);

    // SEND stalled 20 cycles, then reset mid-SEND.
    local_packet = 12'h259;
    local_moved  = 1'b1;
    tick();
    tick();
    local_moved = 1'b0;
    chk1("stall_tx_valid", link.tx_valid, 1'b1);
    bad = 0;
    repeat (20) begin
      tick();
      if (link.tx_valid !== 1'b1 || link.tx_packet !== 12'h259 || curr_player !== 1'b0) bad++;
    end
    chki("stall_unstable_cycles", bad, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_reset();
    chkb("midsend_reset_board");
    chk1("midsend_reset_tx_valid", link.tx_valid, 1'b0);
    chk1("midsend_reset_turn", curr_player, 1'b1);
    chki("midsend_reset_count", int'(move_count), 0);

    // Local edge out of turn, then in turn but off the chess screen.
    player       = 1'b0;
    local_packet = 12'h29A;
    local_moved  = 1'b1;
    bad = 0;
    repeat (4) begin
      tick();
      if (link.tx_valid !== 1'b0 || move_err !== 1'b0) bad++;
    end
    local_moved = 1'b0;
    chki("offturn_activity", bad, 0);
    chkb("offturn_board_held");
    tick();
    player       = 1'b1;
    sys_state    = SPLASH_SCREEN;
    local_packet = 12'hCA2;
    local_moved  = 1'b1;
    bad = 0;
    repeat (4) begin
      tick();
      if (link.tx_valid !== 1'b0 || move_err !== 1'b0) bad++;
    end
    local_moved = 1'b0;
    chki("inactive_activity", bad, 0);
    chkb("inactive_board_held");
    chki("inactive_count_held", int'(move_count), 0);
    sys_state = CHESS_SCREEN;
    tick();
    chki("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
